aoc_day1_line_parser: RTL
=========================

# aoc_day1_line_parser

Byte-stream front end for the day-1 dial solver. Consumes the puzzle input as raw ASCII, one byte per handshake, parses each line of the form `L<decimal>` or `R<decimal>`, and emits a registered rotation record. The record is a direction bit plus a 32-bit magnitude, which drive the solver's `dir_r` and `in_data` inputs directly. `out_valid` qualifies each record; the top level advances the solver only on cycles where `out_valid` is high.

## Interface
- `MAX_DIGITS`, default 10: digits accepted per line; further digits raise an overflow error.
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_byte` input 8: ASCII input character.
- `in_valid` input 1: `in_byte` present this cycle.
- `in_last` input 1: qualifies the final byte of the stream, sampled with `in_valid`.
- `in_ready` output 1: parser accepts a byte this cycle.
- `out_data` output 32: rotation magnitude; held until the next record.
- `dir_r` output 1: 1 = `R` (increment), 0 = `L`; held with `out_data`.
- `out_valid` output 1: one-cycle pulse per record.
- `rec_count` output 16: records emitted; wraps modulo 2^16.
- `err_bad_char` output 1: sticky; an unexpected character was seen.
- `err_overflow` output 1: sticky; a magnitude exceeded 32 bits or `MAX_DIGITS`.
- `done` output 1: sticky; set after the `in_last` byte is processed.

## Operation
- A byte is accepted when `in_valid & in_ready`. `in_ready` is 0 in reset and 1 otherwise, except it is 0 once `done` is set.
- Carriage return (0x0D) is ignored in every state.
- FSM states: IDLE, DIR, DIGITS, SKIP.
- **IDLE** (start of line):
  - `L` (0x4C) or `R` (0x52): latch direction, clear accumulator and digit count, go to DIR.
  - `\n` (0x0A): blank line, stay in IDLE.
  - Any other byte: set `err_bad_char`, go to SKIP.
- **DIR**:
  - Digit `0`–`9`: `acc = d`, count = 1, go to DIGITS.
  - `\n`: set `err_bad_char`, no record, go to IDLE.
  - Any other byte: set `err_bad_char`, go to SKIP.
- **DIGITS**:
  - Digit: `acc = acc*10 + d`, computed as `(acc<<3)+(acc<<1)+d` in 36 bits. If the result exceeds 0xFFFFFFFF, or count would exceed `MAX_DIGITS`, set `err_overflow`, saturate `acc` to 0xFFFFFFFF, and stay in DIGITS.
  - `\n`: emit a record, go to IDLE.
  - Any other byte: set `err_bad_char`, discard the line, go to SKIP.
- **SKIP**: discard bytes until `\n`, then go to IDLE. No record is emitted.
- Emit: `out_data <= acc`, `dir_r <= latched dir`, `out_valid <= 1` for one cycle, `rec_count <= rec_count + 1`.
- `in_last` on an accepted byte is processed as that byte first, then:
  - If the FSM is in DIGITS afterwards, emit a record as if `\n` had followed.
  - Set `done` and return to IDLE in all cases.
- Leading zeros are legal: `L007` yields 7. A magnitude of 0 is legal and emits a record.

## Timing
- Reset values: `out_data`=0, `dir_r`=0, `out_valid`=0, `rec_count`=0, all error flags 0, `done`=0, `in_ready`=0, FSM=IDLE.
- Latency: a terminating byte accepted in cycle N gives `out_valid`=1 in cycle N+1 only. `out_data`/`dir_r` change in N+1 and hold until the next emission.
- Throughput: one byte per cycle, with no bubbles. Back-to-back records need at least 3 bytes each (e.g. `R5\n`), so `out_valid` is never high on consecutive cycles.
- Idle input cycles (`in_valid`=0) change no state.
- Reset asserted mid-line: everything returns to reset values immediately, and the partial line is lost.
- Error flags and `done` clear only on reset.

## Test plan
- Stream `L68\nR48\n`: pulse 1 has `out_data`=68, `dir_r`=0; pulse 2 has 48, `dir_r`=1. Each pulse comes one cycle after its `\n`. `rec_count`=2, no errors.
- Stream `R4294967295\nL4294967296\n`: first record is 0xFFFFFFFF with no error. Second record is 0xFFFFFFFF with `err_overflow`=1.
- Stream `\r\n\nX12\nL\nR7\r\n`: the blank lines and CR are ignored. `X12` and `L` each set `err_bad_char` and emit no record. The only record is 7, `dir_r`=1, and `rec_count`=1.
- Stream `R12`, with `in_last` on `2` and no newline: record 12, `dir_r`=1, one cycle later. `done`=1 and `in_ready`=0 afterwards.
- Stream `L5` with `in_valid` gapped (random 0/1) between bytes, then `0\n`: a single record of 50, with timing relative to the `\n` acceptance only.
- Assert `rst_n`=0 after `R9` of `R99\n`, release, then feed `L3\n`: the only record is 3, `dir_r`=0, `rec_count`=1.

Source files
------------

// File: rtl/aoc_day1_line_parser.sv
// aoc_day1_line_parser
//
// Byte-stream front end for the day-1 dial solver. Parses ASCII lines of the
// form L<decimal> / R<decimal> and emits one registered rotation record per line.
//
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   in_byte      - ASCII input character
//   in_valid     - in_byte present this cycle
//   in_last      - final byte of the stream (sampled with in_valid)
//   in_ready     - parser accepts a byte this cycle
//   out_data     - rotation magnitude, held until the next record
//   dir_r        - 1 = R (increment), 0 = L, held with out_data
//   out_valid    - one-cycle pulse per record
//   rec_count    - number of records emitted, wraps at 2^16
//   err_bad_char - sticky, unexpected character seen
//   err_overflow - sticky, magnitude exceeded 32 bits or MAX_DIGITS
//   done         - sticky, in_last byte has been processed
module aoc_day1_line_parser #(
    parameter int unsigned MAX_DIGITS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        dir_r,
    output logic        out_valid,
    output logic [15:0] rec_count,
    output logic        err_bad_char,
    output logic        err_overflow,
    output logic        done
);

    localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StDir    = 2'd1;
    localparam logic [1:0] StDigits = 2'd2;
    localparam logic [1:0] StSkip   = 2'd3;

    localparam logic [7:0] ChCr = 8'h0D;
    localparam logic [7:0] ChLf = 8'h0A;
    localparam logic [7:0] ChL  = 8'h4C;
    localparam logic [7:0] ChR  = 8'h52;

    logic [1:0]      state_q, state_d;
    logic            dir_q, dir_d;
    logic [31:0]     acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     out_data_q, out_data_d;
    logic            out_dir_q, out_dir_d;
    logic            out_valid_q, out_valid_d;
    logic [15:0]     rec_count_q, rec_count_d;
    logic            err_bad_q, err_bad_d;
    logic            err_ovf_q, err_ovf_d;
    logic            done_q, done_d;

    logic            accept;
    logic            is_digit;
    logic            is_lf;
    logic            emit;
    logic [35:0]     acc_x10;

    // Ready follows the reset pin directly so the first byte after release is taken.
    assign in_ready = rst_n & ~done_q;
    assign accept   = in_valid & in_ready;
    assign is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);
    assign is_lf    = (in_byte == ChLf);
    // acc*10 + d as shift-add; the upper nibble flags a result above 32 bits.
    assign acc_x10  = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {32'b0, in_byte[3:0]};

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_dir_d   = out_dir_q;
        out_valid_d = 1'b0;
        rec_count_d = rec_count_q;
        err_bad_d   = err_bad_q;
        err_ovf_d   = err_ovf_q;
        done_d      = done_q;
        emit        = 1'b0;

        if (accept) begin
            if (in_byte != ChCr) begin
                case (state_q)
                    StIdle: begin
                        if (in_byte == ChL || in_byte == ChR) begin
                            dir_d   = (in_byte == ChR);
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = StDir;
                        end else if (!is_lf) begin
                            err_bad_d = 1'b1;
                            state_d   = StSkip;
                        end
                    end
                    StDir: begin
                        if (is_digit) begin
                            acc_d   = {28'b0, in_byte[3:0]};
                            cnt_d   = CntW'(1);
                            state_d = StDigits;
                        end else begin
                            err_bad_d = 1'b1;
                            state_d   = is_lf ? StIdle : StSkip;
                        end
                    end
                    StDigits: begin
                        if (is_digit) begin
                            if (acc_x10[35:32] != 4'b0 || cnt_q == CntW'(MAX_DIGITS)) begin
                                err_ovf_d = 1'b1;
                                acc_d     = '1;
                            end else begin
                                acc_d = acc_x10[31:0];
                                cnt_d = cnt_q + 1'b1;
                            end
                        end else if (is_lf) begin
                            emit    = 1'b1;
                            state_d = StIdle;
                        end else begin
                            err_bad_d = 1'b1;
                            state_d   = StSkip;
                        end
                    end
                    StSkip: begin
                        if (is_lf) begin
                            state_d = StIdle;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end

            // The last byte is processed first; an unterminated number still emits.
            if (in_last) begin
                if (state_d == StDigits) begin
                    emit = 1'b1;
                end
                state_d = StIdle;
                done_d  = 1'b1;
            end
        end

        if (emit) begin
            out_data_d  = acc_d;
            out_dir_d   = dir_q;
            out_valid_d = 1'b1;
            rec_count_d = rec_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            dir_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_dir_q   <= 1'b0;
            out_valid_q <= 1'b0;
            rec_count_q <= '0;
            err_bad_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_dir_q   <= out_dir_d;
            out_valid_q <= out_valid_d;
            rec_count_q <= rec_count_d;
            err_bad_q   <= err_bad_d;
            err_ovf_q   <= err_ovf_d;
            done_q      <= done_d;
        end
    end

    assign out_data     = out_data_q;
    assign dir_r        = out_dir_q;
    assign out_valid    = out_valid_q;
    assign rec_count    = rec_count_q;
    assign err_bad_char = err_bad_q;
    assign err_overflow = err_ovf_q;
    assign done         = done_q;

endmodule
